// File: rtl/quot_buf.sv
// Result buffer between a stallable divider pipeline and a ready/valid consumer.
// Optional QUOT_BUF_CNT_EN adds a 16-bit delivered-result counter (deliv_cnt).
module quot_buf #(
  parameter int DEPTH = 4,
  parameter int QW    = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       src_start,
  output logic                       div_start,
  input  logic                       div_done,
  input  logic [QW-1:0]              div_quot,
  output logic                       m_valid,
  output logic [QW-1:0]              m_data,
  input  logic                       m_ready,
`ifdef QUOT_BUF_CNT_EN
  output logic [15:0]                deliv_cnt,
`endif
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [QW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full, push, pop;

  // The divider only advances when its result is guaranteed a slot, so
  // overflow cannot happen and a frozen divider never pushes twice.
  assign full      = (level_q == LW'(DEPTH));
  assign m_valid   = (level_q != '0);
  assign pop       = m_valid & m_ready;
  assign div_start = ~rst & src_start & (~full | pop);
  assign push      = div_start & div_done;
  assign m_data    = mem_q[rd_ptr_q];
  assign level     = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= div_quot;
  end

`ifdef QUOT_BUF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pop) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign deliv_cnt = cnt_q;
`endif

endmodule

// File: doc/quot_buf.md
QUOT_BUF -- requirements
Module: quot_buf

Interface
REQ-001 Parameter: DEPTH, 4, number of result entries; power of two, 2..16.
REQ-002 Parameter: QW, 12, quotient width; matches the divider quotient output.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge.
REQ-004 Port: rst  in  1  reset; asynchronous, active-high; one clock only, no other clock domain.
REQ-005 Port: src_start  in  1  upstream request to advance the divider pipeline this cycle.
REQ-006 Port: div_start  out  1  pipeline-advance enable; drives the divider start input.
REQ-007 Port: div_done  in  1  divider done; high = divider output register holds a valid result.
REQ-008 Port: div_quot  in  QW  divider quotient output.
REQ-009 Port: m_valid  out  1  buffer head entry valid.
REQ-010 Port: m_data  out  QW  buffer head quotient.
REQ-011 Port: m_ready  in  1  consumer accepts head when high together with m_valid.
REQ-012 Port: level  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-013 Storage SHALL be a circular FIFO of DEPTH x QW entries with read/write pointers wrapping DEPTH-1 -> 0.
REQ-014 pop = m_valid & m_ready; full = (level == DEPTH).
REQ-015 div_start SHALL be combinational: src_start & (!full | pop); forced 0 while rst is high.
REQ-016 push SHALL occur on a posedge where div_start & div_done; the captured value is div_quot sampled before that edge.
REQ-017 A cycle with div_start low SHALL NOT push, even when div_done is high; the divider is frozen, so each advance yields exactly one push and no result is duplicated or lost.
REQ-018 m_valid SHALL be (level != 0); m_data SHALL be the entry at the read pointer, driven from registers.
REQ-019 Latency: a result pushed at edge N is visible on m_data/m_valid after edge N; no fall-through from div_quot.
REQ-020 Simultaneous push and pop: both pointers advance and level is unchanged, including when full or at level 1.
REQ-021 Push with level 0: no pop is possible that cycle; level becomes 1.
REQ-022 Pop with level 0 SHALL be impossible, since m_valid is low; m_ready is ignored.
REQ-023 Overflow SHALL be structurally prevented by REQ-015; no push is ever discarded.
REQ-024 m_data SHALL hold stable while m_valid & !m_ready.

Reset
REQ-025 Asserting rst SHALL asynchronously clear the pointers, level to 0, m_valid to 0 and any counter to 0; entry contents are don't-care.
REQ-026 Reset mid-operation SHALL flush all buffered results; the first push after release lands in entry 0.
REQ-027 m_data after reset SHALL NOT be checked until m_valid is high.

Configuration
REQ-028 Macro QUOT_BUF_CNT_EN: when defined, add output port deliv_cnt  out  16, incremented by 1 on each pop and wrapping 0xFFFF -> 0x0000; cleared by rst.
REQ-029 Without QUOT_BUF_CNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Fill: src_start=1, div_done=1, div_quot stepping 0x001..0x004, m_ready=0 -> level reaches 4; div_start=0 on the 5th cycle; m_data=0x001.
REQ-031 Full with pop: level 4, m_ready=1, src_start=1, div_quot=0x0AA -> div_start=1, level stays 4, 0x0AA is the last entry drained.
REQ-032 Freeze: div_done=1, src_start=0 for 3 cycles holding div_quot=0x555 -> no push, level unchanged.
REQ-033 Wrap: push and pop 10 results 0x100..0x109 with m_ready=1 -> outputs appear in order, each one cycle after its push, with no gaps.
REQ-034 Reset mid-run: level 3, assert rst for 2 cycles -> m_valid=0 and level=0 immediately; a next push of 0x7FF appears as the head.
REQ-035 With QUOT_BUF_CNT_EN, preset deliv_cnt to 0xFFFE by 0xFFFE pops, then 2 more pops -> deliv_cnt=0x0000.
